// File: rtl/dft_pkg.sv
// Shared types and constants for the 16-point DFT input pairing stage.
package dft_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int   NPTS  = 16;
   localparam int   HALF  = 8;
   localparam logic K_ADD = 1'b0;
   localparam logic K_SUB = 1'b1;

endpackage

// File: rtl/dft_sample_buf.sv
// 16-entry complex sample store: one write port and two asynchronous read
// ports, so both butterfly operands are available in the same cycle.
module dft_sample_buf
   import dft_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                we,
   input  logic [3:0]          waddr,
   input  logic [2*N-1:0]      wdata,
   input  logic [3:0]          raddr_a,
   input  logic [3:0]          raddr_b,
   output logic signed [N-1:0] a_re,
   output logic signed [N-1:0] a_im,
   output logic signed [N-1:0] b_re,
   output logic signed [N-1:0] b_im
);

   // Storage holds {re, im}; contents are don't-care until written.
   logic [2*N-1:0] mem [NPTS];

   // Write port: one sample per accepted input handshake.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign a_re = mem[raddr_a][2*N-1:N];
   assign a_im = mem[raddr_a][N-1:0];
   assign b_re = mem[raddr_b][2*N-1:N];
   assign b_im = mem[raddr_b][N-1:0];

endmodule

// File: rtl/dft_input_pairer.sv
// Collects 16 complex samples, then presents them as butterfly operand pairs
// (x[p], x[p+8]) twice each: first for the add, then for the subtract.
module dft_input_pairer
   import dft_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] in_re,
   input  logic signed [N-1:0] in_im,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] ar,
   output logic signed [N-1:0] ai,
   output logic signed [N-1:0] br,
   output logic signed [N-1:0] bi,
   output logic                k,
   output logic [3:0]          out_idx,
   output logic                out_last
);

   state_t              state, state_nxt;
   logic [3:0]          wr_cnt, wr_cnt_nxt;
   logic [3:0]          rd_cnt, rd_cnt_nxt;
   logic                in_hs, out_hs;
   logic [3:0]          addr_a, addr_b;
   logic signed [N-1:0] a_re, a_im, b_re, b_im;

   // Single-bank buffer: filling and draining are mutually exclusive states,
   // so the two handshakes can never coincide.
   assign in_ready  = (state == FILL);
   assign out_valid = (state == DRAIN);
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;

   // Each pair index p = rd_cnt[3:1] is visited on two consecutive beats.
   assign addr_a = {1'b0, rd_cnt[3:1]};
   assign addr_b = addr_a + 4'(HALF);

   dft_sample_buf #(.N(N)) u_buf (
      .clk     (clk),
      .we      (in_hs),
      .waddr   (wr_cnt),
      .wdata   ({in_re, in_im}),
      .raddr_a (addr_a),
      .raddr_b (addr_b),
      .a_re    (a_re),
      .a_im    (a_im),
      .b_re    (b_re),
      .b_im    (b_im)
   );

   // State and counter registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         state  <= state_nxt;
         wr_cnt <= wr_cnt_nxt;
         rd_cnt <= rd_cnt_nxt;
      end
   end

   // Next-state logic: fill 16 samples, then drain 16 beats.
   always_comb begin
      state_nxt  = state;
      wr_cnt_nxt = wr_cnt;
      rd_cnt_nxt = rd_cnt;
      case (state)
         IDLE: state_nxt = FILL;
         FILL: begin
            if (in_hs) begin
               wr_cnt_nxt = wr_cnt + 4'd1;
               if (wr_cnt == 4'(NPTS - 1)) begin
                  state_nxt  = DRAIN;
                  rd_cnt_nxt = '0;
               end
            end
         end
         DRAIN: begin
            if (out_hs) begin
               rd_cnt_nxt = rd_cnt + 4'd1;
               if (rd_cnt == 4'(NPTS - 1)) state_nxt = FILL;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand outputs are zero outside DRAIN and follow rd_cnt inside it;
   // rd_cnt and the buffer are frozen while stalled, so outputs hold.
   always_comb begin
      ar       = '0;
      ai       = '0;
      br       = '0;
      bi       = '0;
      k        = K_ADD;
      out_idx  = '0;
      out_last = 1'b0;
      if (out_valid) begin
         ar       = a_re;
         ai       = a_im;
         br       = b_re;
         bi       = b_im;
         k        = rd_cnt[0] ? K_SUB : K_ADD;
         out_idx  = rd_cnt;
         out_last = (rd_cnt == 4'(NPTS - 1));
      end
   end

endmodule

// File: tb/tb_dft_input_pairer.sv
// Directed bench for dft_input_pairer with a beat scoreboard.
module tb_dft_input_pairer;

   localparam int N = 32;

   logic                clk = 1'b0;
   logic                rst_n, in_valid, in_ready, out_valid, out_ready;
   logic signed [N-1:0] in_re, in_im, ar, ai, br, bi;
   logic                k, out_last;
   logic [3:0]          out_idx;

   always #5 clk = ~clk;

   dft_input_pairer #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ar        (ar),
      .ai        (ai),
      .br        (br),
      .bi        (bi),
      .k         (k),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   typedef struct packed {
      logic [N-1:0] ar, ai, br, bi;
      logic         k;
      logic [3:0]   idx;
      logic         last;
   } beat_t;

   beat_t        q[$];
   logic [N-1:0] mre[16];
   logic [N-1:0] mim[16];
   int           wc;
   bit           idle;
   int           n_chk  = 0;
   int           n_fail = 0;

   task automatic chk(input string tag, input logic [4*N+5:0] obs, input logic [4*N+5:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic beat_t cur();
      beat_t b;
      b.ar = ar; b.ai = ai; b.br = br; b.bi = bi;
      b.k = k; b.idx = out_idx; b.last = out_last;
      return b;
   endfunction

   // Expected drain for the frame just captured in the model buffer.
   task automatic push_frame();
      for (int r = 0; r < 16; r++) begin
         beat_t b;
         int    p;
         p      = r / 2;
         b.ar   = mre[p];
         b.ai   = mim[p];
         b.br   = mre[p+8];
         b.bi   = mim[p+8];
         b.k    = (r % 2 == 1);
         b.idx  = 4'(r);
         b.last = (r == 15);
         q.push_back(b);
      end
   endtask

   // One clock: check current outputs, update the model, advance.
   task automatic step();
      bit exp_drain, exp_ready;
      if (!rst_n) begin
         @(posedge clk); #1;
         q.delete();
         wc   = 0;
         idle = 1;
         chk("reset_data", cur(), '0);
         chk("reset_hs", {in_ready, out_valid}, '0);
      end else begin
         exp_drain = (q.size() != 0);
         exp_ready = !idle && !exp_drain;
         chk("in_ready", in_ready, exp_ready);
         chk("out_valid", out_valid, exp_drain);
         if (exp_drain) chk($sformatf("beat%0d", q[0].idx), cur(), q[0]);
         if (in_valid && exp_ready) begin
            mre[wc] = in_re;
            mim[wc] = in_im;
            wc++;
            if (wc == 16) begin
               wc = 0;
               push_frame();
            end
         end
         if (exp_drain && out_ready) void'(q.pop_front());
         idle = 0;
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [2*N-1:0] sample(input int mode, input int n);
      case (mode)
         0:       return {N'(n), N'(-n)};
         1:       return n[0] ? {32'h8000_0000, 32'h7FFF_FFFF} : {32'h7FFF_FFFF, 32'h8000_0000};
         2:       return {N'(n + 100), N'(-(n * 3) - 1)};
         default: return n[0] ? {32'h7FFF_FFFF, 32'h7FFF_FFFF} : {32'h8000_0000, 32'h8000_0000};
      endcase
   endfunction

   task automatic feed(input int cnt, input int mode, input bit gaps);
      int acc = 0;
      int guard = 0;
      while (acc < cnt && guard < 200) begin
         bit hs;
         in_valid       = gaps ? (guard % 2 == 0) : 1'b1;
         {in_re, in_im} = sample(mode, acc);
         hs             = in_valid && in_ready;
         step();
         if (hs) acc++;
         guard++;
      end
      in_valid = 1'b0;
      if (acc < cnt) chk("feed_timeout", 4*N+6'(acc), 4*N+6'(cnt));
   endtask

   task automatic drain(input int stall_at, input int stall_len, input int stop_at);
      int guard = 0;
      int stalls = 0;
      while (q.size() > 0 && guard < 200) begin
         if (stop_at >= 0 && int'(q[0].idx) == stop_at) break;
         out_ready = 1'b1;
         if (int'(q[0].idx) == stall_at && stalls < stall_len) begin
            out_ready = 1'b0;
            stalls++;
         end
         in_valid       = (guard % 2 == 1);
         {in_re, in_im} = {32'hDEAD_BEEF, 32'h1234_5678};
         step();
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (guard >= 200) chk("drain_timeout", 4*N+6'(q.size()), '0);
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      step();
      step();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      step();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_re     = '0;
      in_im     = '0;
      wc        = 0;
      idle      = 1;
      #1;
      do_reset();

      // Basic frame x[n] = (n, -n)
      feed(16, 0, 0);
      chk("basic_beat0", cur(), {32'd0, 32'd0, 32'd8, -32'sd8, 1'b0, 4'd0, 1'b0});
      drain(-1, 0, -1);

      // Input gaps, backpressure at beat 3, in_valid pulses during drain
      feed(16, 0, 1);
      drain(3, 0, 3);
      chk("bp_beat3", cur(), {32'd1, -32'sd1, 32'd9, -32'sd9, 1'b1, 4'd3, 1'b0});
      drain(3, 5, -1);

      // Reset after 7 samples, then a clean frame
      feed(7, 2, 0);
      do_reset();
      feed(16, 2, 0);
      drain(-1, 0, -1);

      // Reset at drain beat 9, then a clean frame
      feed(16, 0, 0);
      drain(-1, 0, 9);
      do_reset();
      feed(16, 2, 0);
      drain(-1, 0, -1);

      // Extremes, two back-to-back frames
      feed(16, 1, 0);
      drain(-1, 0, -1);
      feed(16, 3, 0);
      drain(-1, 0, -1);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dft_input_pairer.md
DFT_INPUT_PAIRER -- requirements
Module: dft_input_pairer

Interface
REQ-001 The parameter SHALL be N, default 32, giving the signed two's-complement width of each real and each imaginary sample component.
REQ-002 The ports SHALL be, one per line, as follows:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  the input sample is valid.
- in_ready  output  1  the block accepts an input sample.
- in_re  input  N  real part of the input sample.
- in_im  input  N  imaginary part of the input sample.
- out_valid  output  1  the operand set is valid.
- out_ready  input  1  downstream (complex add/sub stage) accepts the set.
- ar, ai  output  N each  operand A, real and imaginary.
- br, bi  output  N each  operand B, real and imaginary.
- k  output  1  operation select: 0 = add, 1 = subtract.
- out_idx  output  4  beat index 0..15 of the current drain.
- out_last  output  1  high on beat 15.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.

Function
REQ-004 There SHALL be three states: IDLE, FILL and DRAIN.
REQ-005 IDLE SHALL be the reset state and SHALL go to FILL on the next clock edge unconditionally.
REQ-006 In FILL, in_ready SHALL be 1, and out_valid SHALL be 0.
REQ-007 An input handshake (in_valid && in_ready) SHALL write {in_re, in_im} to buffer entry wr_cnt and increment the 4-bit counter wr_cnt.
REQ-008 When the handshake occurs with wr_cnt == 15, the state SHALL go to DRAIN, wr_cnt SHALL wrap to 0, and rd_cnt SHALL be set to 0.
REQ-009 In DRAIN, in_ready SHALL be 0, and out_valid SHALL be 1 starting in the first cycle after the 16th sample is accepted, giving 1-cycle latency.
REQ-010 In beat r = rd_cnt, with p = rd_cnt[3:1], the outputs SHALL be:
- A = x[p];
- B = x[p+8];
- k = rd_cnt[0], so the adder beat precedes the subtract beat;
- out_idx = r;
- out_last = (r == 15).
REQ-011 An output handshake (out_valid && out_ready) SHALL increment rd_cnt.
REQ-012 The handshake on beat 15 SHALL return the state to FILL, so in_ready = 1 in the next cycle.
REQ-013 While out_valid is 1 and out_ready is 0, all output data, k, out_idx and out_last SHALL be held stable.
REQ-014 out_valid SHALL NOT drop before the handshake.
REQ-015 Data SHALL pass unmodified: there is no arithmetic and no width change, and downstream produces the N+1-bit result.
REQ-016 in_valid asserted in IDLE or DRAIN SHALL be ignored, with no write.
REQ-017 Buffer contents SHALL NOT be altered during DRAIN.
REQ-018 Input and output handshakes SHALL never be simultaneous, because the buffer is single-bank.

Reset
REQ-019 rst_n low at a rising edge SHALL force the following:
- state = IDLE;
- wr_cnt = 0 and rd_cnt = 0;
- in_ready = 0 and out_valid = 0;
- ar, ai, br, bi, k, out_idx, out_last = 0.
REQ-020 Reset asserted mid-FILL or mid-DRAIN SHALL discard the partial frame, and the next frame SHALL start at entry 0.
REQ-021 Buffer storage SHALL need no reset.

Structure
REQ-022 Shared package dft_pkg SHALL hold:
- the state enum {IDLE, FILL, DRAIN};
- NPTS = 16;
- HALF = 8;
- K_ADD = 0 and K_SUB = 1.
REQ-023 One sub-module, dft_sample_buf, SHALL be instantiated: 16 x 2N register file, one write port, two asynchronous read ports (addresses p and p+8).
REQ-024 The remaining control logic SHALL stay in dft_input_pairer.

Verification
REQ-025 Basic frame: feed x[n] = (n, -n) for n = 0..15, with out_ready = 1. Required response:
- beat 0: A = (0,0), B = (8,-8), k = 0;
- beat 1: same A and B, k = 1;
- beat 14: A = (7,-7), B = (15,-15), k = 0;
- beat 15: same A and B, k = 1, out_last = 1.
REQ-026 Backpressure: hold out_ready = 0 for 5 cycles at beat 3. Required response: outputs A = (1,-1), B = (9,-9), k = 1, out_idx = 3 stay constant; beat 4 appears only after the handshake.
REQ-027 Input gaps: toggle in_valid 1/0 during FILL. Required response: exactly 16 accepted samples are captured, and in_valid pulses during DRAIN leave in_ready = 0 and the buffer unchanged.
REQ-028 Reset mid-operation:
- assert rst_n = 0 after 7 samples: all outputs are 0, and the next 16 samples form a clean frame starting at x[0];
- repeat at drain beat 9: the same result is required.
REQ-029 Extremes and back-to-back: use N = 32 samples 0x7FFFFFFF and 0x80000000, over two consecutive frames. Required response:
- values pass bit-exact;
- in_ready rises the cycle after beat 15 is accepted;
- the second frame's data is not mixed with the first.
